// File: rtl/sparc_sr_pkg.sv
// -----------------------------------------------------------------------------
// sparc_sr_pkg
//   Shared definitions for the SPARC special register file:
//     - PSR bit positions (icc, PIL, S, PS, ET, CWP)
//     - WR-state-register target encodings (Wr_Sel)
//     - run/error state enum
//     - TBR field widths
//     - helpers for the WIM valid-window mask and CWP range checks
// -----------------------------------------------------------------------------
package sparc_sr_pkg;

    // PSR field positions
    localparam int ICC_MSB = 23;
    localparam int ICC_LSB = 20;
    localparam int PIL_MSB = 11;
    localparam int PIL_LSB = 8;
    localparam int S_BIT   = 7;
    localparam int PS_BIT  = 6;
    localparam int ET_BIT  = 5;
    localparam int CWP_MSB = 4;

    // Wr_Sel encodings
    localparam logic [1:0] WR_SEL_PSR  = 2'b00;
    localparam logic [1:0] WR_SEL_TBR  = 2'b01;
    localparam logic [1:0] WR_SEL_WIM  = 2'b10;
    localparam logic [1:0] WR_SEL_NONE = 2'b11;

    // TBR field widths: TBA[31:12], tt[11:4], zero[3:0]
    localparam int TBA_W = 20;
    localparam int TT_W  = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } sr_state_e;

    // One bit per implemented window; bits at or above nwin read as zero.
    function automatic logic [31:0] wim_mask(input int nwin);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < nwin);
        end
        return m;
    endfunction

    // True when a CWP value names an implemented window.
    function automatic logic cwp_in_range(input logic [4:0] cwp, input int nwin);
        return (32'(cwp) < 32'(nwin));
    endfunction

endpackage

// File: rtl/cwp_window_ctrl.sv
// -----------------------------------------------------------------------------
// cwp_window_ctrl
//   Computes the neighbouring window pointers modulo NWINDOWS and whether a
//   move into them is blocked by the window invalid mask.
//   Ports:
//     cwp             in   current window pointer (always < NWINDOWS)
//     wim             in   window invalid mask
//     cwp_dec         out  (cwp - 1) mod NWINDOWS   (Save, trap entry)
//     cwp_inc         out  (cwp + 1) mod NWINDOWS   (Restore, Rett)
//     save_blocked    out  WIM bit of cwp_dec is set (overflow on Save)
//     restore_blocked out  WIM bit of cwp_inc is set (underflow on Restore)
// -----------------------------------------------------------------------------
module cwp_window_ctrl #(
    parameter int NWINDOWS = 8
) (
    input  logic [4:0]  cwp,
    input  logic [31:0] wim,
    output logic [4:0]  cwp_dec,
    output logic [4:0]  cwp_inc,
    output logic        save_blocked,
    output logic        restore_blocked
);

    localparam logic [4:0] CWP_LAST = 5'(NWINDOWS - 1);

    // Explicit wrap compares rather than a modulo operator: NWINDOWS need
    // not be a power of two.
    assign cwp_dec = (cwp == 5'd0)     ? CWP_LAST : cwp - 5'd1;
    assign cwp_inc = (cwp == CWP_LAST) ? 5'd0     : cwp + 5'd1;

    assign save_blocked    = wim[cwp_dec];
    assign restore_blocked = wim[cwp_inc];

endmodule

// File: rtl/special_register_file.sv
// -----------------------------------------------------------------------------
// special_register_file
//   SPARC processor state registers PSR, TBR, WIM, PC and nPC with trap
//   entry, RETT, SAVE/RESTORE window moves, WR writes, icc updates and
//   PC/nPC sequencing. A trap taken with ET=0 enters a sticky error state
//   that freezes everything until Reset.
//
//   Per-cycle priority in RUN: Trap_Req > Rett > Wr_En > {Save/Restore,
//   Advance}. Save/Restore and Advance combine in the same cycle.
//
//   Optional macro WR_DELAY_EN: WR writes go to a single pending slot and
//   commit on the third applied Advance; a newer write replaces the pending
//   one and restarts the count; a trap or Reset discards it. Without the
//   macro, writes commit on the next clock edge.
//
//   Ports:
//     Clk, Reset (sync, active-high)
//     Advance, Branch_Taken, Branch_Target   instruction retire / PC update
//     Trap_Req, Trap_Type                    trap entry
//     Rett, Save, Restore                    window moves
//     Wr_En, Wr_Sel, Wr_Data                 WR to PSR/TBR/WIM
//     ICC_En, ICC_In                         icc load (with Advance)
//     PSR, TBR, WIM, PC, nPC                 register outputs
//     Window_Overflow, Window_Underflow,
//     Illegal_Write                          one-cycle event pulses
//     Error_Mode                             sticky halt indicator
// -----------------------------------------------------------------------------
module special_register_file
    import sparc_sr_pkg::*;
#(
    parameter int          NWINDOWS = 8,
    parameter logic [7:0]  IMPL_VER = 8'hF0,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Advance,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Trap_Req,
    input  logic [7:0]  Trap_Type,
    input  logic        Rett,
    input  logic        Save,
    input  logic        Restore,
    input  logic        Wr_En,
    input  logic [1:0]  Wr_Sel,
    input  logic [31:0] Wr_Data,
    input  logic        ICC_En,
    input  logic [3:0]  ICC_In,
    output logic [31:0] PSR,
    output logic [31:0] TBR,
    output logic [31:0] WIM,
    output logic [31:0] PC,
    output logic [31:0] nPC,
    output logic        Window_Overflow,
    output logic        Window_Underflow,
    output logic        Illegal_Write,
    output logic        Error_Mode
);

    localparam logic [31:0] WIM_MASK = wim_mask(NWINDOWS);

    sr_state_e          state_q, state_d;
    logic [3:0]         icc_q, icc_d;
    logic [3:0]         pil_q, pil_d;
    logic               s_q, s_d;
    logic               ps_q, ps_d;
    logic               et_q, et_d;
    logic [4:0]         cwp_q, cwp_d;
    logic [TBA_W-1:0]   tba_q, tba_d;
    logic [TT_W-1:0]    tt_q, tt_d;
    logic [31:0]        wim_q, wim_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        npc_q, npc_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               ill_q, ill_d;

    // Write actually landing in a register this cycle (direct or from the
    // pending slot).
    logic               commit_en;
    logic [1:0]         commit_sel;
    logic [31:0]        commit_data;
    logic [31:0]        trap_pc;

    logic [4:0]         cwp_dec, cwp_inc;
    logic               save_blocked, restore_blocked;

`ifdef WR_DELAY_EN
    // Pending count 0,1,2: the Advance seen at count 2 is the third one.
    localparam logic [1:0] WR_DELAY_LAST = 2'd2;

    logic               pend_valid_q, pend_valid_d;
    logic [1:0]         pend_sel_q, pend_sel_d;
    logic [31:0]        pend_data_q, pend_data_d;
    logic [1:0]         pend_cnt_q, pend_cnt_d;
`endif

    cwp_window_ctrl #(
        .NWINDOWS(NWINDOWS)
    ) u_cwp_window_ctrl (
        .cwp            (cwp_q),
        .wim            (wim_q),
        .cwp_dec        (cwp_dec),
        .cwp_inc        (cwp_inc),
        .save_blocked   (save_blocked),
        .restore_blocked(restore_blocked)
    );

    assign trap_pc = {tba_q, Trap_Type, 4'h0};

    always_comb begin
        // NOTE: every signal written here gets its hold/default value first,
        // so no path through the if/case tree can leave it unassigned and
        // infer a latch.
        state_d     = state_q;
        icc_d       = icc_q;
        pil_d       = pil_q;
        s_d         = s_q;
        ps_d        = ps_q;
        et_d        = et_q;
        cwp_d       = cwp_q;
        tba_d       = tba_q;
        tt_d        = tt_q;
        wim_d       = wim_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        ill_d       = 1'b0;
        commit_en   = 1'b0;
        commit_sel  = Wr_Sel;
        commit_data = Wr_Data;
`ifdef WR_DELAY_EN
        pend_valid_d = pend_valid_q;
        pend_sel_d   = pend_sel_q;
        pend_data_d  = pend_data_q;
        pend_cnt_d   = pend_cnt_q;
`endif

        // ST_ERROR falls through with everything held.
        if (state_q == ST_RUN) begin
            if (Trap_Req) begin
                if (et_q) begin
                    // Trap entry moves the window without consulting WIM.
                    ps_d  = s_q;
                    s_d   = 1'b1;
                    et_d  = 1'b0;
                    cwp_d = cwp_dec;
                    tt_d  = Trap_Type;
                    pc_d  = trap_pc;
                    npc_d = trap_pc + 32'd4;
`ifdef WR_DELAY_EN
                    pend_valid_d = 1'b0;
`endif
                end else begin
                    state_d = ST_ERROR;
                end
            end else if (Rett) begin
                s_d   = ps_q;
                et_d  = 1'b1;
                cwp_d = cwp_inc;
                pc_d  = npc_q;
                npc_d = Branch_Target;
            end else if (Wr_En) begin
`ifdef WR_DELAY_EN
                // Illegal PSR writes are rejected at issue and never occupy
                // the slot; Wr_Sel=11 is ignored and leaves the slot alone.
                if (Wr_Sel == WR_SEL_PSR && !cwp_in_range(Wr_Data[CWP_MSB:0], NWINDOWS)) begin
                    ill_d = 1'b1;
                end else if (Wr_Sel != WR_SEL_NONE) begin
                    pend_valid_d = 1'b1;
                    pend_sel_d   = Wr_Sel;
                    pend_data_d  = Wr_Data;
                    pend_cnt_d   = 2'd0;
                end
`else
                commit_en = 1'b1;
`endif
            end else begin
                // Save and Restore together cancel out.
                if (Save && !Restore) begin
                    if (save_blocked) ovf_d = 1'b1;
                    else              cwp_d = cwp_dec;
                end else if (Restore && !Save) begin
                    if (restore_blocked) unf_d = 1'b1;
                    else                 cwp_d = cwp_inc;
                end

                if (Advance) begin
                    pc_d  = npc_q;
                    npc_d = Branch_Taken ? Branch_Target : npc_q + 32'd4;
                    if (ICC_En) icc_d = ICC_In;
`ifdef WR_DELAY_EN
                    if (pend_valid_q) begin
                        if (pend_cnt_q == WR_DELAY_LAST) begin
                            commit_en    = 1'b1;
                            commit_sel   = pend_sel_q;
                            commit_data  = pend_data_q;
                            pend_valid_d = 1'b0;
                        end else begin
                            pend_cnt_d = pend_cnt_q + 2'd1;
                        end
                    end
`endif
                end
            end

            // A committing write overrides same-cycle icc/CWP updates of the
            // register it targets.
            if (commit_en) begin
                unique case (commit_sel)
                    WR_SEL_PSR: begin
                        if (cwp_in_range(commit_data[CWP_MSB:0], NWINDOWS)) begin
                            icc_d = commit_data[ICC_MSB:ICC_LSB];
                            pil_d = commit_data[PIL_MSB:PIL_LSB];
                            s_d   = commit_data[S_BIT];
                            ps_d  = commit_data[PS_BIT];
                            et_d  = commit_data[ET_BIT];
                            cwp_d = commit_data[CWP_MSB:0];
                        end else begin
                            ill_d = 1'b1;
                        end
                    end
                    WR_SEL_TBR: tba_d = commit_data[31:32-TBA_W];
                    WR_SEL_WIM: wim_d = commit_data & WIM_MASK;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: state updates use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q <= ST_RUN;
            icc_q   <= 4'h0;
            pil_q   <= 4'h0;
            s_q     <= 1'b1;
            ps_q    <= 1'b0;
            et_q    <= 1'b0;
            cwp_q   <= 5'd0;
            tba_q   <= '0;
            tt_q    <= '0;
            wim_q   <= 32'h0;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + 32'd4;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            icc_q   <= icc_d;
            pil_q   <= pil_d;
            s_q     <= s_d;
            ps_q    <= ps_d;
            et_q    <= et_d;
            cwp_q   <= cwp_d;
            tba_q   <= tba_d;
            tt_q    <= tt_d;
            wim_q   <= wim_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ill_q   <= ill_d;
        end
    end

`ifdef WR_DELAY_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_valid_q <= 1'b0;
            pend_cnt_q   <= 2'd0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_cnt_q   <= pend_cnt_d;
        end
    end

    // NOTE: the slot payload is qualified by pend_valid_q, so it carries no
    // reset; only the control bits do.
    always_ff @(posedge Clk) begin
        pend_sel_q  <= pend_sel_d;
        pend_data_q <= pend_data_d;
    end
`endif

    assign PSR = {IMPL_VER, icc_q, 8'h00, pil_q, s_q, ps_q, et_q, cwp_q};
    assign TBR = {tba_q, tt_q, 4'h0};
    assign WIM = wim_q;
    assign PC  = pc_q;
    assign nPC = npc_q;

    assign Window_Overflow  = ovf_q;
    assign Window_Underflow = unf_q;
    assign Illegal_Write    = ill_q;
    assign Error_Mode       = (state_q == ST_ERROR);

endmodule
